// File: rtl/path_sequencer_if.sv
// Planner/line-follower side-band bundle for path_sequencer.
// The master drives path memory, run control and node events; the slave returns turn decisions and status.
interface path_sequencer_if #(
    parameter int AW = 5
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;
    logic [AW:0]   path_len;
    logic          start;
    logic          abort;
    logic          node_flag;
    logic          node_changed;
    logic [1:0]    turn_flag;
    logic          end_path;
    logic          busy;
    logic [AW-1:0] node_idx;
    logic          aborted;
    logic          fault;

    modport master (
        output wr_en, wr_addr, wr_data, path_len, start, abort, node_flag, node_changed,
        input  turn_flag, end_path, busy, node_idx, aborted, fault
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, path_len, start, abort, node_flag, node_changed,
        output turn_flag, end_path, busy, node_idx, aborted, fault
    );
endinterface

// File: rtl/path_sequencer.sv
// Path memory of 2-bit turn codes stepped one entry per accepted node exit, with end/abort handling.
// Optional node watchdog enabled by defining PATH_SEQUENCER_TURN_TIMEOUT_EN.
module path_sequencer #(
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int MIN_GAP      = 3125,
    parameter int TURN_TIMEOUT = 6250000
) (
    input  logic             clk_3125KHz,
    input  logic             rst_n,
    path_sequencer_if.slave  bus
);
    localparam int          GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          busy_r, busy_s;
    logic          end_r, end_s;
    logic [1:0]    turn_r, turn_s;
    logic [AW-1:0] idx_r, idx_s;
    logic          aborted_r, aborted_s;
    logic [AW:0]   len_r, len_s;
    logic [GW-1:0] gap_r, gap_s;
    logic [AW:0]   next_idx_s;
    logic          start_ok_s;
    logic          wd_trip_s;
    logic [1:0]    mem_r [DEPTH];

    assign start_ok_s = (state_r != ST_RUN) && bus.start && !bus.abort;
    assign next_idx_s = {1'b0, idx_r} + (AW + 1)'(1);

    // Path memory: synchronous write, locked while a run is in progress, never reset.
    always_ff @(posedge clk_3125KHz) begin
        if (bus.wr_en && (state_r != ST_RUN)) begin
            mem_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            mem_r[bus.wr_addr] <= mem_r[bus.wr_addr];
        end
    end

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_s   = state_r;
        busy_s    = busy_r;
        end_s     = end_r;
        turn_s    = turn_r;
        idx_s     = idx_r;
        aborted_s = aborted_r;
        len_s     = len_r;
        gap_s     = (gap_r != '0) ? (gap_r - GW'(1)) : gap_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    len_s     = (bus.path_len > DEPTH_L) ? DEPTH_L : bus.path_len;
                    idx_s     = '0;
                    aborted_s = 1'b0;
                    if (bus.path_len == '0) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        end_s   = 1'b1;
                        turn_s  = 2'd0;
                    end else begin
                        state_s = ST_RUN;
                        busy_s  = 1'b1;
                        end_s   = 1'b0;
                        turn_s  = mem_r[0];
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                // Abort and watchdog trips take precedence over any node event.
                if (bus.abort || wd_trip_s) begin
                    state_s   = ST_DONE;
                    busy_s    = 1'b0;
                    end_s     = 1'b1;
                    aborted_s = 1'b1;
                    turn_s    = 2'd0;
                end else if (bus.node_changed && (gap_r == '0)) begin
                    gap_s = GAP_LOAD;
                    if (next_idx_s == len_r) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        end_s   = 1'b1;
                        turn_s  = 2'd0;
                    end else begin
                        idx_s  = next_idx_s[AW-1:0];
                        turn_s = mem_r[next_idx_s[AW-1:0]];
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                end_s   = 1'b0;
                turn_s  = 2'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            end_r     <= 1'b0;
            turn_r    <= 2'd0;
            idx_r     <= '0;
            aborted_r <= 1'b0;
            len_r     <= '0;
            gap_r     <= '0;
        end else begin
            state_r   <= state_s;
            busy_r    <= busy_s;
            end_r     <= end_s;
            turn_r    <= turn_s;
            idx_r     <= idx_s;
            aborted_r <= aborted_s;
            len_r     <= len_s;
            gap_r     <= gap_s;
        end
    end

`ifdef PATH_SEQUENCER_TURN_TIMEOUT_EN
    localparam logic [22:0] WD_LAST = 23'(TURN_TIMEOUT - 1);

    logic [22:0] wd_r;
    logic        fault_r;

    assign wd_trip_s = busy_r && bus.node_flag && (wd_r == WD_LAST);

    // Node watchdog: counts while the follower sits on a node during a run.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= 23'd0;
        end else if (busy_r && bus.node_flag && !wd_trip_s) begin
            wd_r <= wd_r + 23'd1;
        end else begin
            wd_r <= 23'd0;
        end
    end

    // Sticky fault flag, cleared only by the next accepted start.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (start_ok_s) begin
            fault_r <= 1'b0;
        end else if ((state_r == ST_RUN) && wd_trip_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign bus.fault = fault_r;
`else
    assign wd_trip_s = 1'b0;
    assign bus.fault = 1'b0;
`endif

    assign bus.turn_flag = turn_r;
    assign bus.end_path  = end_r;
    assign bus.busy      = busy_r;
    assign bus.node_idx  = idx_r;
    assign bus.aborted   = aborted_r;
endmodule

// File: tb/tb_path_sequencer.sv
// Directed self-checking bench for path_sequencer (MIN_GAP=3125, TURN_TIMEOUT=50).
module tb_path_sequencer;
    localparam int AW = 5;

    logic clk_3125KHz = 1'b0;
    logic rst_n       = 1'b0;
    int   n_checks    = 0;
    int   n_errors    = 0;

    path_sequencer_if #(.AW(AW)) bus ();

    path_sequencer #(
        .DEPTH(32), .AW(AW), .MIN_GAP(3125), .TURN_TIMEOUT(50)
    ) dut (
        .clk_3125KHz(clk_3125KHz),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_3125KHz);
            #1;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic pulse_node();
        bus.node_changed = 1'b1; tick(); bus.node_changed = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    endtask

    logic [1:0] codes [4];

    initial begin
        codes[0] = 2'd1; codes[1] = 2'd3; codes[2] = 2'd0; codes[3] = 2'd2;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 2'd0; bus.path_len = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.node_flag = 1'b0; bus.node_changed = 1'b0;

        tick(3);
        chk("rst_turn", bus.turn_flag, 0);
        chk("rst_end", bus.end_path, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_idx", bus.node_idx, 0);
        chk("rst_aborted", bus.aborted, 0);
        chk("rst_fault", bus.fault, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) wr(AW'(i), codes[i]);

        // Full run: 1,3,0,2 then end.
        bus.path_len = 6'd4;
        pulse_start();
        chk("run_busy", bus.busy, 1);
        chk("run_turn0", bus.turn_flag, 1);
        chk("run_idx0", bus.node_idx, 0);
        pulse_node();
        chk("run_turn1", bus.turn_flag, 3);
        chk("run_idx1", bus.node_idx, 1);
        wr(5'd1, 2'd2);
        tick(4000);
        pulse_node();
        chk("run_turn2", bus.turn_flag, 0);
        tick(4000);
        pulse_node();
        chk("run_turn3", bus.turn_flag, 2);
        chk("run_idx3", bus.node_idx, 3);
        tick(4000);
        pulse_node();
        chk("end_end", bus.end_path, 1);
        chk("end_busy", bus.busy, 0);
        chk("end_turn", bus.turn_flag, 0);
        chk("end_idx", bus.node_idx, 3);
        tick(4000);

        // Restart from DONE; memory must be untouched by the write in RUN.
        pulse_start();
        chk("rs_end_drop", bus.end_path, 0);
        chk("rs_turn0", bus.turn_flag, 1);
        pulse_node();
        chk("rs_idx1", bus.node_idx, 1);
        chk("rs_turn1_unchanged", bus.turn_flag, 3);
        tick(99);
        pulse_node();
        chk("gap100_a", bus.node_idx, 1);
        tick(99);
        pulse_node();
        chk("gap100_b", bus.node_idx, 1);
        tick(2923);
        pulse_node();
        chk("gap3124_rej", bus.node_idx, 1);
        pulse_node();
        chk("gap3125_idx", bus.node_idx, 2);
        chk("gap3125_turn", bus.turn_flag, 0);

        // Abort at index 2.
        pulse_abort();
        chk("ab_end", bus.end_path, 1);
        chk("ab_aborted", bus.aborted, 1);
        chk("ab_turn", bus.turn_flag, 0);
        chk("ab_busy", bus.busy, 0);
        pulse_abort();
        chk("ab_done_end", bus.end_path, 1);
        chk("ab_done_aborted", bus.aborted, 1);
        bus.abort = 1'b1; bus.start = 1'b1; tick(); bus.abort = 1'b0; bus.start = 1'b0;
        chk("abst_done_busy", bus.busy, 0);
        chk("abst_done_end", bus.end_path, 1);

        // Zero-length path.
        bus.path_len = 6'd0;
        pulse_start();
        chk("len0_end", bus.end_path, 1);
        chk("len0_busy", bus.busy, 0);
        chk("len0_aborted", bus.aborted, 0);
        tick();
        chk("len0_busy2", bus.busy, 0);

        // Mid-run asynchronous reset.
        bus.path_len = 6'd4;
        pulse_start();
        chk("mr_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy0", bus.busy, 0);
        chk("mr_turn0", bus.turn_flag, 0);
        chk("mr_idx0", bus.node_idx, 0);
        chk("mr_end0", bus.end_path, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.abort = 1'b1; bus.start = 1'b1; tick(); bus.abort = 1'b0; bus.start = 1'b0;
        chk("abst_idle_busy", bus.busy, 0);
        chk("abst_idle_end", bus.end_path, 0);
        pulse_start();
        chk("mr2_turn0", bus.turn_flag, 1);
        chk("mr2_idx0", bus.node_idx, 0);
        pulse_node();
        chk("mr2_idx1", bus.node_idx, 1);
        chk("mr2_turn1", bus.turn_flag, 3);

        // Node held high: watchdog trips only when built in.
        bus.node_flag = 1'b1;
`ifdef PATH_SEQUENCER_TURN_TIMEOUT_EN
        tick(49);
        chk("wd_pre_fault", bus.fault, 0);
        chk("wd_pre_busy", bus.busy, 1);
        tick();
        chk("wd_fault", bus.fault, 1);
        chk("wd_end", bus.end_path, 1);
        chk("wd_aborted", bus.aborted, 1);
        tick(10);
        chk("wd_fault_sticky", bus.fault, 1);
`else
        tick(60);
        chk("nowd_fault", bus.fault, 0);
        chk("nowd_busy", bus.busy, 1);
        chk("nowd_end", bus.end_path, 0);
        chk("nowd_turn", bus.turn_flag, 3);
`endif
        bus.node_flag = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
